maxpool_seq_9bit: RTL

//  Max-pooling sequencer for the TPU 9-bit sign-magnitude datapath (bit 8 = sign, bits 7:0 = magnitude).

---
 rtl/tpu_sm9_pkg.sv | 32 +++
 rtl/max_9bit.sv | 13 +
 rtl/maxpool_seq_9bit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tpu_sm9_pkg.sv
// Shared types and helpers for the TPU 9-bit sign-magnitude datapath
// (bit 8 = sign, bits 7:0 = magnitude).
package tpu_sm9_pkg;

  typedef logic [8:0] sm9_t;

  localparam sm9_t SM9_NEG_ZERO = 9'h100;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } pool_state_e;

  // Folds -0 onto +0 so that equal values are also bit-identical downstream.
  function automatic sm9_t sm9_norm(input sm9_t v);
    return (v == SM9_NEG_ZERO) ? 9'h000 : v;
  endfunction

  // Strict a > b in sign-magnitude; +0 and -0 compare equal.
  function automatic logic sm9_gt(input sm9_t a, input sm9_t b);
    logic [7:0] ma;
    logic [7:0] mb;
    ma = a[7:0];
    mb = b[7:0];
    if (ma == 8'd0 && mb == 8'd0) return 1'b0;
    if (a[8] != b[8])             return b[8];
    if (!a[8])                    return ma > mb;
    return ma < mb;
  endfunction

endpackage

// File: rtl/max_9bit.sv
// Combinational sign-magnitude maximum. On a tie the first operand (a) is
// returned, so the incumbent of a running maximum is kept.
module max_9bit
  import tpu_sm9_pkg::*;
(
  input  sm9_t a,
  input  sm9_t b,
  output sm9_t y
);

  assign y = sm9_gt(b, a) ? b : a;

endmodule

// File: rtl/maxpool_seq_9bit.sv
// Max-pooling sequencer: folds win_len elements into a running maximum and
// emits one result per window. Define MAXPOOL_ARGMAX_EN to add out_idx.
module maxpool_seq_9bit
  import tpu_sm9_pkg::*;
#(
  parameter  int MAX_WIN = 16,
  parameter  int DW      = 9,
  localparam int CW      = $clog2(MAX_WIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] win_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
`ifdef MAXPOOL_ARGMAX_EN
  output logic [CW-1:0] out_idx,
`endif
  output logic          busy
);

  pool_state_e   state_q, state_d;
  sm9_t          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
`ifdef MAXPOOL_ARGMAX_EN
  logic [CW-1:0] idx_q, idx_d;
`endif

  sm9_t          norm_in;
  sm9_t          max_y;
  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] len_start;

  assign norm_in = sm9_norm(in_data);
  assign accept  = in_valid && in_ready_q;
  assign cnt_inc = cnt_q + CW'(1);

  // Window length of 0 degenerates to a single element; oversize clamps.
  assign len_start = (win_len == '0)               ? CW'(1) :
                     (win_len > CW'(MAX_WIN))      ? CW'(MAX_WIN) :
                                                     win_len;

  max_9bit u_max (
    .a (acc_q),
    .b (norm_in),
    .y (max_y)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
`ifdef MAXPOOL_ARGMAX_EN
    idx_d   = idx_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = norm_in;
          cnt_d   = CW'(1);
          len_d   = len_start;
`ifdef MAXPOOL_ARGMAX_EN
          idx_d   = '0;
`endif
          state_d = (len_start == CW'(1)) ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = max_y;
          cnt_d = cnt_inc;
`ifdef MAXPOOL_ARGMAX_EN
          if (sm9_gt(norm_in, acc_q)) idx_d = cnt_q;
`endif
          if (cnt_inc == len_q) state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state.
    in_ready_d  = (state_d != OUT);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
      idx_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MAXPOOL_ARGMAX_EN
      idx_q       <= idx_d;
`endif
    end
  end

  // acc cannot change in OUT (in_ready is low), so out_data holds stable.
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign busy      = busy_q;
`ifdef MAXPOOL_ARGMAX_EN
  assign out_idx   = idx_q;
`endif

endmodule
